// File: rtl/manchester_byte_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_byte_decoder
//  Description : Recovers bits from a clk-synchronous Manchester line, packs
//                them LSB-first into words and hands them out via valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module manchester_byte_decoder #(
    parameter int SPB        = 8,
    parameter int DATA_WIDTH = 8,
    parameter int IDLE_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  sync_ether,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  bit_out,
    output logic                  bit_strobe,
    output logic                  idle,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int PH_W = (SPB > 2) ? $clog2(SPB) : 1;
    localparam int BC_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam int MC_W = (IDLE_BITS > 2) ? $clog2(IDLE_BITS) : 1;

    localparam logic [PH_W-1:0] c_ph_zero    = '0;
    localparam logic [PH_W-1:0] c_ph_one     = PH_W'(1);
    localparam logic [PH_W-1:0] c_ph_quarter = PH_W'(SPB / 4);
    localparam logic [PH_W-1:0] c_ph_half    = PH_W'(SPB / 2);
    localparam logic [PH_W-1:0] c_ph_max     = PH_W'(SPB - 1);
    localparam logic [BC_W-1:0] c_bc_zero    = '0;
    localparam logic [BC_W-1:0] c_bc_one     = BC_W'(1);
    localparam logic [BC_W-1:0] c_bc_last    = BC_W'(DATA_WIDTH - 1);
    localparam logic [MC_W-1:0] c_mc_one     = MC_W'(1);
    localparam logic [MC_W-1:0] c_mc_last    = MC_W'(IDLE_BITS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    logic [0:0]            r_state;
    logic [PH_W-1:0]       r_ph;
    logic                  r_prev_line;
    logic                  r_edge_seen;
    logic [MC_W-1:0]       r_miss_cnt;
    logic [BC_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_bit_out;
    logic                  r_bit_strobe;
    logic                  r_idle;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic [0:0]            w_state_nx;
    logic [PH_W-1:0]       w_ph_nx;
    logic                  w_edge_seen_nx;
    logic [MC_W-1:0]       w_miss_cnt_nx;
    logic [BC_W-1:0]       w_bit_cnt_nx;
    logic [DATA_WIDTH-1:0] w_shreg_nx;
    logic                  w_edge;
    logic                  w_mid_edge;
    logic                  w_commit;
    logic                  w_word_done;
    logic                  w_frame_abort;
    logic                  w_load;

    assign w_edge = (sync_ether != r_prev_line);

    // An edge seen at ph==0 arrives one cycle after the wrap: it is a late
    // mid-bit edge, so accepting it keeps +1 cycle of jitter decodable.
    assign w_mid_edge = w_edge && ((r_ph > c_ph_half) || (r_ph == c_ph_zero));

    always_comb begin
        w_state_nx     = r_state;
        w_ph_nx        = r_ph;
        w_edge_seen_nx = r_edge_seen;
        w_miss_cnt_nx  = r_miss_cnt;
        w_bit_cnt_nx   = r_bit_cnt;
        w_shreg_nx     = r_shreg;
        w_commit       = 1'b0;
        w_word_done    = 1'b0;
        w_frame_abort  = 1'b0;

        if (!enable) begin
            w_state_nx     = S_IDLE;
            w_ph_nx        = c_ph_zero;
            w_edge_seen_nx = 1'b0;
            w_miss_cnt_nx  = '0;
            w_bit_cnt_nx   = c_bc_zero;
            w_shreg_nx     = '0;
        end else if (r_state == S_IDLE) begin
            w_ph_nx = c_ph_zero;
            if (w_edge) begin
                w_state_nx     = S_RECV;
                w_edge_seen_nx = 1'b1;
                w_miss_cnt_nx  = '0;
            end
        end else begin
            if (r_edge_seen && (r_ph == c_ph_quarter)) begin
                w_commit               = 1'b1;
                w_edge_seen_nx         = 1'b0;
                w_shreg_nx[r_bit_cnt]  = r_prev_line;
                if (r_bit_cnt == c_bc_last) begin
                    w_word_done  = 1'b1;
                    w_bit_cnt_nx = c_bc_zero;
                end else begin
                    w_bit_cnt_nx = r_bit_cnt + c_bc_one;
                end
            end

            if (w_mid_edge) begin
                w_ph_nx        = c_ph_zero;
                w_edge_seen_nx = 1'b1;
                w_miss_cnt_nx  = '0;
            end else if (r_ph == c_ph_max) begin
                w_ph_nx = c_ph_zero;
                if (r_miss_cnt == c_mc_last) begin
                    w_state_nx     = S_IDLE;
                    w_miss_cnt_nx  = '0;
                    w_edge_seen_nx = 1'b0;
                    w_frame_abort  = (r_bit_cnt != c_bc_zero);
                    w_bit_cnt_nx   = c_bc_zero;
                    w_shreg_nx     = '0;
                end else begin
                    w_miss_cnt_nx = r_miss_cnt + c_mc_one;
                end
            end else begin
                w_ph_nx = r_ph + c_ph_one;
            end
        end
    end

    // A completed word may replace the held one only if the slot is free or
    // being consumed in this same cycle.
    assign w_load = w_word_done && (!r_rx_valid || rx_ready);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_ph        <= c_ph_zero;
            r_prev_line <= 1'b1;
            r_edge_seen <= 1'b0;
            r_miss_cnt  <= '0;
            r_bit_cnt   <= c_bc_zero;
            r_shreg     <= '0;
            r_idle      <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_ph        <= w_ph_nx;
            r_prev_line <= sync_ether;
            r_edge_seen <= w_edge_seen_nx;
            r_miss_cnt  <= w_miss_cnt_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_shreg     <= w_shreg_nx;
            r_idle      <= (w_state_nx == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_bit_out    <= 1'b0;
            r_bit_strobe <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_bit_strobe <= w_commit;
            if (w_commit) begin
                r_bit_out <= r_prev_line;
            end
            r_frame_err <= w_frame_abort;
            r_overrun   <= w_word_done && r_rx_valid && !rx_ready;
            if (w_load) begin
                r_rx_data  <= w_shreg_nx;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign bit_out    = r_bit_out;
    assign bit_strobe = r_bit_strobe;
    assign idle       = r_idle;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_manchester_byte_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_manchester_byte_decoder
//  Description : Directed self-checking bench for manchester_byte_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_manchester_byte_decoder;

    localparam int SPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       sync_ether = 1'b1;
    logic       enable = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       bit_out;
    logic       bit_strobe;
    logic       idle;
    logic       frame_err;
    logic       overrun;

    int          checks = 0;
    int          errors = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          strobe_n = 0;
    logic [31:0] strobe_word = '0;

    manchester_byte_decoder #(
        .SPB        (SPB),
        .DATA_WIDTH (8),
        .IDLE_BITS  (2)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sync_ether (sync_ether),
        .enable     (enable),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .bit_out    (bit_out),
        .bit_strobe (bit_strobe),
        .idle       (idle),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Pulse monitor: collects decoded bits and counts one-cycle error pulses.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (bit_strobe === 1'b1) begin
                if (strobe_n < 32) strobe_word[strobe_n] = bit_out;
                strobe_n++;
            end
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        fe_cnt      = 0;
        ov_cnt      = 0;
        strobe_n    = 0;
        strobe_word = '0;
    endtask

    task automatic apply_reset();
        n_rst      = 1'b0;
        enable     = 1'b1;
        rx_ready   = 1'b0;
        sync_ether = 1'b1;
        tick(3);
        n_rst = 1'b1;
        tick(2);
        clear_mon();
    endtask

    // First half carries ~b, second half b; j shifts the mid-bit edge.
    task automatic send_bit(input logic b, input int j);
        sync_ether = ~b;
        tick(SPB / 2 + j);
        sync_ether = b;
        tick(SPB / 2 - j);
    endtask

    // Moves the line to the first-half level of b0 without it being decoded.
    task automatic prep_line(input logic b0);
        if (sync_ether !== ~b0) begin
            enable = 1'b0;
            tick(1);
            sync_ether = ~b0;
            tick(2);
            enable = 1'b1;
            tick(1);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit jitter);
        int j;
        for (int i = 0; i < 8; i++) begin
            j = 0;
            if (jitter) begin
                if (i % 4 == 1) j = 1;
                else if (i % 4 == 3) j = -1;
            end
            send_bit(w[i], j);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; enable = 1'b1; rx_ready = 1'b0; sync_ether = 1'b1;
        tick(2);
        @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %b expected 0", bit_out); end
        checks++; if (bit_strobe !== 1'b0) begin errors++; $display("FAIL reset_bit_strobe: got %b expected 0", bit_strobe); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        n_rst = 1'b1;
        tick(4);
        @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_after_release: got %b expected 1", idle); end
    endtask

    task automatic test_first_bit();
        apply_reset();
        sync_ether = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bit_strobe !== 1'b0) begin errors++; $display("FAIL strobe_early_fall: got %b expected 0", bit_strobe); end
        @(negedge clk);
        checks++; if (bit_strobe !== 1'b1) begin errors++; $display("FAIL strobe_t4_fall: got %b expected 1", bit_strobe); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL bit_out_fall: got %b expected 0", bit_out); end
        apply_reset();
        prep_line(1'b1);
        tick(1);
        sync_ether = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bit_strobe !== 1'b0) begin errors++; $display("FAIL strobe_early_rise: got %b expected 0", bit_strobe); end
        @(negedge clk);
        checks++; if (bit_strobe !== 1'b1) begin errors++; $display("FAIL strobe_t4_rise: got %b expected 1", bit_strobe); end
        checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL bit_out_rise: got %b expected 1", bit_out); end
    endtask

    task automatic test_word_a5();
        apply_reset();
        prep_line(1'b1);
        clear_mon();
        send_word(8'hA5, 1'b0);
        @(negedge clk);
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL a5_idle_during: got %b expected 0", idle); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL a5_valid_early: got %b expected 1", rx_valid); end
        tick(2 * SPB + 4);
        @(negedge clk);
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data: got %h expected a5", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL a5_rx_valid: got %b expected 1", rx_valid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL a5_idle_after: got %b expected 1", idle); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL a5_frame_err: got %0d expected 0", fe_cnt); end
        checks++; if (strobe_n !== 8) begin errors++; $display("FAIL a5_strobes: got %0d expected 8", strobe_n); end
        checks++; if (strobe_word[7:0] !== 8'hA5) begin errors++; $display("FAIL a5_bit_out: got %h expected a5", strobe_word[7:0]); end
    endtask

    task automatic test_frame_err();
        logic [4:0] pat;
        pat = 5'b10110;
        apply_reset();
        clear_mon();
        for (int i = 0; i < 5; i++) send_bit(pat[i], 0);
        @(negedge clk);
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL fe_idle_during: got %b expected 0", idle); end
        tick(2 * SPB + 4);
        @(negedge clk);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL fe_pulse: got %0d expected 1", fe_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL fe_idle_after: got %b expected 1", idle); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL fe_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (strobe_word[4:0] !== 5'b10110) begin errors++; $display("FAIL fe_bits: got %b expected 10110", strobe_word[4:0]); end
        tick(2 * SPB);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL fe_single: got %0d expected 1", fe_cnt); end
    endtask

    task automatic test_overrun();
        apply_reset();
        clear_mon();
        send_word(8'h3C, 1'b0);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ov_first_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ov_first_data: got %h expected 3c", rx_data); end
        send_word(8'h81, 1'b0);
        tick(2 * SPB + 4);
        @(negedge clk);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ov_pulse: got %0d expected 1", ov_cnt); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ov_data_kept: got %h expected 3c", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ov_valid_kept: got %b expected 1", rx_valid); end
        checks++; if (strobe_word[15:0] !== 16'h813C) begin errors++; $display("FAIL ov_bits: got %h expected 813c", strobe_word[15:0]); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL ov_frame_err: got %0d expected 0", fe_cnt); end
        tick(1);
        rx_ready = 1'b1;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL hs_same_cycle: got %b expected 1", rx_valid); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL hs_cleared: got %b expected 0", rx_valid); end
        rx_ready = 1'b0;
    endtask

    task automatic test_jitter();
        apply_reset();
        prep_line(1'b1);
        clear_mon();
        send_word(8'h55, 1'b1);
        tick(2 * SPB + 4);
        @(negedge clk);
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL jit_rx_data: got %h expected 55", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL jit_rx_valid: got %b expected 1", rx_valid); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL jit_frame_err: got %0d expected 0", fe_cnt); end
        checks++; if (strobe_n !== 8) begin errors++; $display("FAIL jit_strobes: got %0d expected 8", strobe_n); end
    endtask

    task automatic test_reset_midframe();
        logic [3:0] pat;
        pat = 4'b1110;
        apply_reset();
        for (int i = 0; i < 4; i++) send_bit(pat[i], 0);
        n_rst = 1'b0;
        tick(3);
        @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rm_idle_in_reset: got %b expected 1", idle); end
        n_rst = 1'b1;
        tick(2);
        clear_mon();
        prep_line(1'b1);
        send_word(8'h0F, 1'b0);
        tick(2 * SPB + 4);
        @(negedge clk);
        checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL rm_rx_data: got %h expected 0f", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rm_rx_valid: got %b expected 1", rx_valid); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL rm_frame_err: got %0d expected 0", fe_cnt); end
        checks++; if (strobe_n !== 8) begin errors++; $display("FAIL rm_strobes: got %0d expected 8", strobe_n); end
    endtask

    task automatic test_enable();
        apply_reset();
        send_word(8'h3C, 1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        clear_mon();
        enable = 1'b0;
        tick(1);
        @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL en_idle: got %b expected 1", idle); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL en_valid_kept: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL en_data_kept: got %h expected 3c", rx_data); end
        tick(2 * SPB + 4);
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL en_frame_err: got %0d expected 0", fe_cnt); end
        rx_ready = 1'b1;
        tick(2);
        rx_ready = 1'b0;
        enable = 1'b1;
        tick(2);
        prep_line(1'b0);
        send_word(8'h96, 1'b0);
        tick(2 * SPB + 4);
        @(negedge clk);
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL en_next_word: got %h expected 96", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL en_next_valid: got %b expected 1", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_first_bit();
        test_word_a5();
        test_frame_err();
        test_overrun();
        test_jitter();
        test_reset_midframe();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/manchester_byte_decoder.md
MANCHESTER_BYTE_DECODER -- requirements
Module: manchester_byte_decoder

Interface
REQ-001 Parameter SPB, default 8: clock cycles per Manchester bit period; SHALL be even and at least 4.
REQ-002 Parameter DATA_WIDTH, default 8: bits per assembled word; SHALL be at least 2.
REQ-003 Parameter IDLE_BITS, default 2: consecutive bit periods without a mid-bit edge that end a frame; SHALL be at least 1.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 n_rst  in  1  reset, asynchronous assert, active-low.
REQ-006 sync_ether  in  1  line input, already synchronised to clk.
REQ-007 enable  in  1  0 forces IDLE and clears the assembly state.
REQ-008 rx_data  out  DATA_WIDTH  assembled word, first-received bit in bit 0.
REQ-009 rx_valid  out  1  rx_data holds an unconsumed word.
REQ-010 rx_ready  in  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1.
REQ-011 bit_out, bit_strobe  out  1 each  decoded bit value and one-cycle qualifier.
REQ-012 idle  out  1  1 while in IDLE.
REQ-013 frame_err, overrun  out  1 each  one-cycle error pulses.

Function
REQ-014 The block SHALL register the line as prev_line every cycle; edge = (sync_ether != prev_line).
REQ-015 States SHALL be IDLE and RECV; the phase counter ph SHALL count 0..SPB-1 and wrap to 0.
REQ-016 In IDLE with enable=1, an edge SHALL be treated as the mid-bit edge of bit 0: next state RECV, ph:=0, edge_seen:=1.
REQ-017 In RECV, ph SHALL increment every cycle; an edge with ph > SPB/2 SHALL be a mid-bit edge (ph:=0, edge_seen:=1, miss_cnt:=0).
REQ-018 In RECV, an edge with 1 <= ph <= SPB/2 SHALL be a bit-boundary edge and SHALL be ignored.
REQ-019 When ph == SPB/4 and edge_seen=1, the block SHALL commit bit = prev_line and clear edge_seen.
REQ-020 On a commit, the block SHALL shift the bit into the assembly register at index bit_cnt and increment bit_cnt.
REQ-021 On a commit, bit_out SHALL carry the committed bit and bit_strobe SHALL be 1 in the next cycle only.
REQ-022 When ph wraps from SPB-1 to 0 with no mid-bit edge in that period, miss_cnt SHALL increment and no bit SHALL be committed.
REQ-023 When miss_cnt reaches IDLE_BITS, the block SHALL return to IDLE.
REQ-024 On that return to IDLE, if bit_cnt != 0, frame_err SHALL pulse for 1 cycle and the partial word SHALL be discarded; bit_cnt:=0.
REQ-025 When bit_cnt reaches DATA_WIDTH, the word SHALL be loaded into rx_data with rx_valid:=1 in the next cycle, and bit_cnt:=0.
REQ-026 rx_valid SHALL clear the cycle after a handshake unless a new word loads in the same cycle; a load SHALL take priority.
REQ-027 If a word completes while rx_valid=1 and rx_ready=0, the new word SHALL be dropped, rx_data SHALL be unchanged and overrun SHALL pulse for 1 cycle.
REQ-028 enable=0 SHALL force IDLE with bit_cnt, miss_cnt and edge_seen cleared; rx_valid/rx_data SHALL be retained until handshake.
REQ-029 idle SHALL equal (state == IDLE), registered.

Reset
REQ-030 While n_rst=0, outputs SHALL be: rx_data=0, rx_valid=0, bit_out=0, bit_strobe=0, frame_err=0, overrun=0, idle=1.
REQ-031 While n_rst=0, internal state SHALL be: state=IDLE, ph=0, bit_cnt=0, miss_cnt=0, edge_seen=0, prev_line=1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no frame_err pulse.

Verification
REQ-033 SPB=8, idle-high line, first edge at cycle t -> bit_strobe=1 at t+4, with bit_out equal to the post-edge level.
REQ-034 Encode 0xA5 LSB-first followed by 2 edge-free periods -> rx_data=0xA5, rx_valid=1, idle returns to 1, frame_err=0.
REQ-035 Encode 5 bits then hold the line -> after 2 bit periods, frame_err pulses once, idle=1, rx_valid stays 0.
REQ-036 Encode 0x3C then 0x81 with rx_ready=0 -> overrun pulses once, rx_data stays 0x3C; rx_ready=1 -> rx_valid clears the next cycle.
REQ-037 Jitter the mid-bit edges by +/-1 cycle over a 0x55 word -> rx_data=0x55, no frame_err.
REQ-038 Assert n_rst=0 after 4 bits, then release and send 0x0F -> rx_data=0x0F, with no stale bits.
